// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/grant/response bus
interface fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        gnt;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage, one request in flight, single output slot
// Optional feature macro: FETCH_STALL_COUNTER_EN (adds StallCountF decode-stall counter)
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         StallF,
   input  logic         PCSrcE,
   input  logic [31:0]  PCTargetE,
   fetch_unit_if.master imem,
   output logic [31:0]  PCF,
   output logic [31:0]  PCPlus4F,
   output logic [31:0]  InstrF,
   output logic         ValidF
`ifdef FETCH_STALL_COUNTER_EN
   ,
   output logic [31:0]  StallCountF
`endif
);

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_DROP
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] areq_q, areq_d;
   logic        redir_q, redir_d;
   logic [31:0] pcf_q, pcf_d;
   logic [31:0] pcp4_q, pcp4_d;
   logic [31:0] instr_q, instr_d;
   logic        valid_q, valid_d;

   logic        cons;
   logic        new_req;
   logic        req_c;
   logic [31:0] addr_c;

   // slot is free now or is being handed to decode at this edge
   assign cons = !valid_q || !StallF;

   // next-state, request and slot update logic
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      areq_d   = areq_q;
      redir_d  = redir_q;
      pcf_d    = pcf_q;
      pcp4_d   = pcp4_q;
      instr_d  = instr_q;
      valid_d  = valid_q && StallF;
      req_c    = 1'b0;
      addr_c   = pc_q;
      new_req  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            new_req = cons && !PCSrcE;
         end
         ST_REQ: begin
            // address held on areq until the memory accepts it
            req_c  = 1'b1;
            addr_c = areq_q;
            if (imem.gnt) begin
               if (PCSrcE || redir_q) begin
                  state_d = ST_DROP;
                  redir_d = 1'b0;
               end else begin
                  state_d = ST_WAIT;
                  pc_d    = areq_q + 32'd4;
               end
            end else if (PCSrcE) begin
               redir_d = 1'b1;
            end
         end
         ST_WAIT: begin
            if (imem.rvalid) begin
               if (!PCSrcE) begin
                  instr_d = imem.rdata;
                  pcf_d   = areq_q;
                  pcp4_d  = areq_q + 32'd4;
                  valid_d = 1'b1;
               end
               state_d = ST_IDLE;
               new_req = cons && !PCSrcE;
            end
         end
         ST_DROP: begin
            if (imem.rvalid) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // a fresh request for pc, shared by IDLE and back-to-back WAIT
      if (new_req) begin
         req_c  = 1'b1;
         addr_c = pc_q;
         areq_d = pc_q;
         if (imem.gnt) begin
            state_d = ST_WAIT;
            pc_d    = pc_q + 32'd4;
         end else begin
            state_d = ST_REQ;
         end
      end

      // redirect overrides stall, fill and sequential pc advance
      if (PCSrcE) begin
         pc_d    = PCTargetE;
         valid_d = 1'b0;
         if (state_q == ST_WAIT && !imem.rvalid) begin
            state_d = ST_DROP;
         end
      end
   end

   assign imem.req  = req_c;
   assign imem.addr = addr_c;

   // state and slot registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pc_q    <= RESET_PC;
         areq_q  <= 32'd0;
         redir_q <= 1'b0;
         pcf_q   <= 32'd0;
         pcp4_q  <= 32'd0;
         instr_q <= NOP;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         areq_q  <= areq_d;
         redir_q <= redir_d;
         pcf_q   <= pcf_d;
         pcp4_q  <= pcp4_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
      end
   end

   assign PCF      = pcf_q;
   assign PCPlus4F = pcp4_q;
   assign InstrF   = instr_q;
   assign ValidF   = valid_q;

`ifdef FETCH_STALL_COUNTER_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt_d = stall_cnt_q + 32'd1;

   // counts edges where a real instruction is held back by decode
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q <= 32'd0;
      end else if (valid_q && StallF && !PCSrcE) begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign StallCountF = stall_cnt_q;
`endif

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 5-stage RV32I pipeline. Owns the fetch PC. Issues word requests to the instruction memory over a grant/response handshake, and keeps at most one request in flight. Holds one fetched instruction in an output slot that drives the fetch-to-decode pipeline register. It honours decode-side stalls and execute-stage redirects (taken branches and jumps), discarding wrong-path responses.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- StallF  in  1  decode not accepting; the slot is consumed at an edge where ValidF=1 and StallF=0
- PCSrcE  in  1  redirect request
- PCTargetE  in  32  redirect target
- imem_req  out  1  request valid
- imem_addr  out  32  request word address
- imem_gnt  in  1  request accepted this cycle
- imem_rvalid  in  1  response valid; cannot be backpressured
- imem_rdata  in  32  response instruction
- PCF  out  32  address of the slot instruction
- PCPlus4F  out  32  PCF+4
- InstrF  out  32  slot instruction
- ValidF  out  1  slot holds a real instruction

## Operation
- Internal state: `pc` (next fetch address), `areq` (latched request address), FSM {IDLE, REQ, WAIT, DROP}.
- Consume condition: `cons` = !ValidF || !StallF, meaning the slot is free or is freed at this edge.
- **IDLE:**
  - imem_req = cons && !PCSrcE; imem_addr = pc.
  - If req and gnt: go to WAIT, pc <= pc+4, areq <= pc.
  - If req and no gnt: go to REQ, areq <= pc.
- **REQ:**
  - imem_req = 1; imem_addr = areq. imem_req and imem_addr hold stable until gnt.
  - On gnt: go to WAIT, pc <= areq+4.
- **WAIT:**
  - On rvalid: slot is filled (InstrF <= rdata, PCF <= areq, PCPlus4F <= areq+4, ValidF <= 1).
  - In the same cycle, a new request for pc is issued when cons && !PCSrcE, using the same gnt rules as IDLE. Otherwise the FSM goes to IDLE.
- **DROP:** imem_req = 0. The next rvalid is discarded, then the FSM goes to IDLE.
- A response can only arrive for a request issued when the slot was free or being consumed, so the slot never overflows.
- **Redirect (PCSrcE=1 at an edge):** takes priority over stall and over fill.
  - pc <= PCTargetE; ValidF <= 0.
  - IDLE: stay in IDLE.
  - WAIT without rvalid: go to DROP.
  - WAIT with rvalid: the response is discarded; go to IDLE.
  - REQ without gnt: stay in REQ. The address stays areq; the redirect is latched and the FSM goes to DROP on gnt.
  - REQ with gnt: go to DROP.
  - Any redirect in the same cycle as a simultaneous new request suppresses that new request.
- A second redirect while a redirect is latched or in DROP only updates pc.
- All address arithmetic is mod 2^32; pc+4 wraps from 32'hFFFF_FFFC to 0.

## Timing
- Reset values (immediate, asynchronous): state IDLE, pc=RESET_PC, areq=0, PCF=0, PCPlus4F=0, InstrF=32'h0000_0013 (NOP), ValidF=0.
- imem_req is 1 with imem_addr=RESET_PC in the first cycle after rst falls.
- Fetch latency: slot filled at the edge where imem_rvalid=1.
- Throughput: 1 instruction/cycle with same-cycle gnt and 1-cycle response.
- After a redirect edge, the target request is issued:
  - in the next cycle if no request is outstanding;
  - otherwise in the cycle after the discarded response.
- Reset mid-request: the outstanding response is not tracked. The memory is reset by the same rst.

## Configuration
- FETCH_STALL_COUNTER_EN defined:
  - Adds output StallCountF (32 bits). Reset 0.
  - Increments at each edge where ValidF=1 && StallF=1 && PCSrcE=0.
  - Wraps from 32'hFFFF_FFFF to 0.
- Not defined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset release, gnt=1 always, rvalid 1 cycle later, rdata=addr^32'hA5A5_0000 -> addrs 0,4,8,… on consecutive cycles; ValidF stays 1; PCF follows 0,4,8.
- StallF=1 for 3 cycles with slot full -> no imem_req; PCF/InstrF held; after release, next request address = PCF+4. With macro: StallCountF=3.
- gnt held 0 for 4 cycles -> imem_req=1 and imem_addr constant throughout; fetch proceeds normally after gnt.
- PCSrcE=1, PCTargetE=32'h0000_0100 while in WAIT -> ValidF=0; next response discarded; next request addr 32'h100; PCF=32'h100 on fill.
- Redirect to 32'h200 in the same cycle as rvalid, plus redirect during an ungranted REQ -> the response is not loaded; the request is granted at the old address, then dropped; the next fetch is 32'h200.
- PCTargetE=32'hFFFF_FFFC -> PCF=32'hFFFF_FFFC, PCPlus4F=0, following fetch addr 0.
